// File: rtl/conv_2d_pkg.sv
// Shared types for the strided binary-kernel 2D convolution (conv_2d).
package conv_2d_pkg;

  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] data_t;

  typedef enum logic {
    COMPUTE = 1'b0,
    DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/conv_2d_window_sum.sv
// Combinational K*K masked tap sum for one window of the flattened image,
// with 32-bit two's-complement wrap-around accumulation.
module conv_2d_window_sum
  import conv_2d_pkg::*;
#(
  parameter int K     = 3,
  parameter int W     = 5,
  parameter int ORG_W = 3
) (
  input  logic [W*W*DATA_W-1:0] image_i,
  input  logic [K*K-1:0]        filter_i,
  input  logic [ORG_W-1:0]      row_i,
  input  logic [ORG_W-1:0]      col_i,
  output data_t                 sum_o
);

  localparam int BIT_W = $clog2(W*W*DATA_W);

  int               pix;
  logic [BIT_W-1:0] base;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the loops can leave it unassigned and infer a latch.
  always_comb begin
    sum_o = '0;
    pix   = 0;
    base  = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        pix  = (int'(row_i) + i) * W + int'(col_i) + j;
        base = BIT_W'(pix * DATA_W);
        if (filter_i[i*K+j]) begin
          sum_o = sum_o + data_t'(image_i[base +: DATA_W]);
        end
      end
    end
  end

endmodule

// File: rtl/conv_2d.sv
// Strided 2D convolution producing one output pixel per clock, then holding.
// Optional build macro CONV_2D_FUSED_RELU_EN clamps negative results to 0.
module conv_2d
  import conv_2d_pkg::*;
#(
  parameter int kernel_size  = 3,
  parameter int stride       = 2,
  parameter int input_width  = 5,
  parameter int output_width = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [kernel_size*kernel_size-1:0]            filter,
  input  logic [input_width*input_width*DATA_W-1:0]     input_image,
  output logic [output_width*output_width*DATA_W-1:0]   output_image,
  output logic                                          done
);

  localparam int K     = kernel_size;
  localparam int W     = input_width;
  localparam int O     = output_width;
  localparam int N     = O * O;
  localparam int RC_W  = (O > 1) ? $clog2(O) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ORG_W = (W > 1) ? $clog2(W) : 1;

  if (output_width != (input_width - kernel_size) / stride + 1) begin : g_cfg_err
    $error("conv_2d: output_width must equal (input_width-kernel_size)/stride+1");
  end

  state_t            state_q, state_d;
  logic [RC_W-1:0]   r_q, r_d, c_q, c_d;
  data_t             out_q [N];
  data_t             out_d [N];
  logic [IDX_W-1:0]  idx;
  logic [ORG_W-1:0]  org_row, org_col;
  data_t             sum, result;

  conv_2d_window_sum #(
    .K     (K),
    .W     (W),
    .ORG_W (ORG_W)
  ) u_window_sum (
    .image_i  (input_image),
    .filter_i (filter),
    .row_i    (org_row),
    .col_i    (org_col),
    .sum_o    (sum)
  );

  always_comb begin
    org_row = ORG_W'(int'(r_q) * stride);
    org_col = ORG_W'(int'(c_q) * stride);
    idx     = IDX_W'(int'(r_q) * O + int'(c_q));
`ifdef CONV_2D_FUSED_RELU_EN
    result  = sum[DATA_W-1] ? data_t'(0) : sum;
`else
    result  = sum;
`endif
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    out_d   = out_q;
    if (state_q == COMPUTE) begin
      out_d[idx] = result;
      if (c_q == RC_W'(O - 1)) begin
        c_d = '0;
        if (r_q == RC_W'(O - 1)) begin
          state_d = DONE;
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // NOTE: the result array is real state that must read 0 out of reset, so it
  // is reset like any other flop rather than left as an unreset memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COMPUTE;
      r_q     <= '0;
      c_q     <= '0;
      for (int k = 0; k < N; k++) out_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      out_q   <= out_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign output_image[k*DATA_W +: DATA_W] = out_q[k];
  end

  assign done = (state_q == DONE);

endmodule

// File: tb/tb_conv_2d.sv
// Scoreboard bench for conv_2d with default parameters.
module tb_conv_2d;

  localparam int K  = 3;
  localparam int S  = 2;
  localparam int W  = 5;
  localparam int O  = 2;
  localparam int N  = O * O;
  localparam int DW = 32;
  localparam int IW = W * W * DW;
  localparam int OW = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [K*K-1:0] filter;
  logic [IW-1:0] input_image;
  logic [OW-1:0] output_image;
  logic          done;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] exp_q [$];

  conv_2d #(
    .kernel_size  (K),
    .stride       (S),
    .input_width  (W),
    .output_width (O)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .filter       (filter),
    .input_image  (input_image),
    .output_image (output_image),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] out_at(int k);
    logic [OW-1:0] t;
    t = output_image >> (k * DW);
    return t[DW-1:0];
  endfunction

  task automatic fill_const(input logic [DW-1:0] v);
    logic [IW-1:0] w;
    input_image = '0;
    for (int p = 0; p < W*W; p++) begin
      w = '0;
      w[DW-1:0] = v;
      input_image = input_image | (w << (p * DW));
    end
  endtask

  task automatic fill_ramp();
    logic [IW-1:0] w;
    input_image = '0;
    for (int p = 0; p < W*W; p++) begin
      w = '0;
      w[DW-1:0] = DW'(p);
      input_image = input_image | (w << (p * DW));
    end
  endtask

  task automatic push4(input logic [DW-1:0] a, b, c, d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic start();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Steps one edge per output index and checks the freshly written result,
  // done timing, and that later results are still zero.
  task automatic run_and_check(input string name);
    logic [DW-1:0] e;
    logic          e_done;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s out[%0d]: scoreboard empty", name, k);
      end else begin
        e = exp_q.pop_front();
        if (out_at(k) !== e) begin
          miscompares++;
          $display("FAIL %s out[%0d]: got %h expected %h", name, k, out_at(k), e);
        end
      end
      e_done = (k == N - 1);
      vectors++;
      if (done !== e_done) begin
        miscompares++;
        $display("FAIL %s done after edge %0d: got %b expected %b", name, k + 1, done, e_done);
      end
      for (int m = k + 1; m < N; m++) begin
        vectors++;
        if (out_at(m) !== '0) begin
          miscompares++;
          $display("FAIL %s unwritten out[%0d] after edge %0d: got %h expected 0", name, m, k + 1, out_at(m));
        end
      end
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scoreboard: %0d entries left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    fill_ramp();
    filter = '1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (output_image !== '0) begin
      miscompares++;
      $display("FAIL reset output_image: got %h expected 0", output_image);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset done: got %b expected 0", done);
    end
  endtask

  task automatic test_ramp();
    fill_ramp();
    filter = 9'b101010101;
    push4(32'd30, 32'd40, 32'd80, 32'd90);
    start();
    run_and_check("ramp");
  endtask

  task automatic test_ones_and_zero_filter();
    fill_const(32'd1);
    filter = 9'b111111111;
    push4(32'd9, 32'd9, 32'd9, 32'd9);
    start();
    run_and_check("ones");
    filter = 9'b000000000;
    push4(32'd0, 32'd0, 32'd0, 32'd0);
    start();
    run_and_check("zero_filter");
  endtask

  task automatic test_overflow();
    fill_const(32'h7FFFFFFF);
    filter = 9'b000000011;
    push4(32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE);
    start();
    run_and_check("overflow");
  endtask

  task automatic test_negative();
    logic [DW-1:0] e;
`ifdef CONV_2D_FUSED_RELU_EN
    e = 32'd0;
`else
    e = 32'hFFFFFFF7;
`endif
    fill_const(32'hFFFFFFFF);
    filter = 9'b111111111;
    push4(e, e, e, e);
    start();
    run_and_check("negative");
  endtask

  task automatic test_mid_reset();
    fill_const(32'd1);
    filter = 9'b111111111;
    start();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_at(1) !== 32'd9) begin
      miscompares++;
      $display("FAIL mid_reset pre out[1]: got %h expected 9", out_at(1));
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (output_image !== '0) begin
      miscompares++;
      $display("FAIL mid_reset async output_image: got %h expected 0", output_image);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset async done: got %b expected 0", done);
    end
    @(negedge clk);
    reset = 1'b0;
    push4(32'd9, 32'd9, 32'd9, 32'd9);
    run_and_check("mid_reset_recompute");
  endtask

  task automatic test_hold_in_done();
    logic [DW-1:0] e;
    fill_ramp();
    filter = 9'b101010101;
    push4(32'd30, 32'd40, 32'd80, 32'd90);
    start();
    run_and_check("hold_setup");
    fill_const(32'h12345678);
    filter = 9'b111111111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    push4(32'd30, 32'd40, 32'd80, 32'd90);
    for (int k = 0; k < N; k++) begin
      e = exp_q.pop_front();
      vectors++;
      if (out_at(k) !== e) begin
        miscompares++;
        $display("FAIL hold out[%0d]: got %h expected %h", k, out_at(k), e);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL hold done: got %b expected 1", done);
    end
  endtask

  initial begin
    reset = 1'b1;
    filter = '0;
    input_image = '0;
    test_reset();
    test_ramp();
    test_ones_and_zero_filter();
    test_overflow();
    test_negative();
    test_mid_reset();
    test_hold_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
